// File: rtl/wb_uart_pkg.sv
// Shared types and register-map constants for the Wishbone UART transmitter.
package wb_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_DIV    = 2'd2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_PARITY    = 4;
    localparam int STAT_LEVEL_LSB = 8;

endpackage

// File: rtl/if_wb.sv
// Wishbone classic bus bundle with 16-bit data; the responder decodes only adr[1:0].
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat_m;
    logic [15:0] dat_s;
    logic        ack;

    modport master (output cyc, stb, we, adr, dat_m, input dat_s, ack);
    modport slave  (input cyc, stb, we, adr, dat_m, output dat_s, ack);
endinterface

// File: rtl/wb_uart_tx_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with synchronous reset; DEPTH must be a power of 2.
module sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_en;
    logic             pop_en;

    // A push into a full FIFO succeeds only when a pop frees the head slot in the same cycle.
    assign pop_en  = pop && (count != '0);
    assign push_en = push && ((count != FULL_LEVEL) || pop_en);

    // NOTE: storage is deliberately left out of reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == FULL_LEVEL);
    assign empty = (count == '0);
    assign level = count;
endmodule

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone slave that queues bytes and sends them 8N1, LSB first, at DIV+1 clocks/bit.
// Define WB_UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module wb_uart_tx
    import wb_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    if_wb.slave  wb,
    output logic tx_o,
    output logic irq_o
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       reg_adr;
    logic             access;
    logic             wr_data;
    logic             ack;
    logic             overflow;
    logic [15:0]      dat_s;
    logic [15:0]      div;
    logic [15:0]      status;
    logic [15:0]      rdata;
    logic             unused_adr;

    logic [7:0]       fifo_rdata;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    tx_state_e        state;
    logic [7:0]       shift;
    logic [15:0]      bit_cnt;
    logic [15:0]      div_lat;
    logic [2:0]       bit_idx;
`ifdef WB_UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    assign reg_adr    = wb.adr[1:0];
    assign unused_adr = ^wb.adr[15:2];
    assign access     = wb.cyc && wb.stb && !ack;
    assign wr_data    = access && wb.we && (reg_adr == ADR_DATA);
    assign wb.ack     = ack;
    assign wb.dat_s   = dat_s;

    // A new frame starts from IDLE or straight out of the last stop-bit clock, so frames run gapless.
    assign fifo_pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && (bit_cnt == '0)));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk_i),
        .rst   (sys_rst_i),
        .push  (wr_data),
        .wdata (wb.dat_m[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        status                          = '0;
        status[STAT_BUSY]               = (state != IDLE);
        status[STAT_FULL]               = fifo_full;
        status[STAT_EMPTY]              = fifo_empty;
        status[STAT_OVF]                = overflow;
        status[STAT_LEVEL_LSB +: 8]     = 8'(fifo_level);
`ifdef WB_UART_TX_PARITY_EN
        status[STAT_PARITY]             = 1'b1;
`endif
        rdata = '0;
        case (reg_adr)
            ADR_STATUS: rdata = status;
            ADR_DIV:    rdata = div;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ack      <= 1'b0;
            dat_s    <= '0;
            div      <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            ack   <= access;
            dat_s <= (access && !wb.we) ? rdata : '0;
            if (access && wb.we) begin
                case (reg_adr)
                    ADR_STATUS: if (wb.dat_m[STAT_OVF]) overflow <= 1'b0;
                    ADR_DIV:    div <= wb.dat_m;
                    default:    ;
                endcase
            end
            if (wr_data && fifo_full && !fifo_pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state   <= IDLE;
            tx_o    <= 1'b1;
            irq_o   <= 1'b1;
            shift   <= '0;
            bit_cnt <= '0;
            div_lat <= '0;
            bit_idx <= '0;
`ifdef WB_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            irq_o <= fifo_empty && (state == IDLE);
            if (fifo_pop) begin
                state   <= START;
                tx_o    <= 1'b0;
                shift   <= fifo_rdata;
                bit_cnt <= div;
                div_lat <= div;
`ifdef WB_UART_TX_PARITY_EN
                parity_bit <= ^fifo_rdata;
`endif
            end else begin
                case (state)
                    START: begin
                        if (bit_cnt == '0) begin
                            state   <= DATA;
                            tx_o    <= shift[0];
                            bit_cnt <= div_lat;
                            bit_idx <= '0;
                        end else begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end
                    end
                    DATA: begin
                        if (bit_cnt == '0) begin
                            bit_cnt <= div_lat;
                            if (bit_idx == 3'd7) begin
`ifdef WB_UART_TX_PARITY_EN
                                state <= PARITY;
                                tx_o  <= parity_bit;
`else
                                state <= STOP;
                                tx_o  <= 1'b1;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                shift   <= shift >> 1;
                                tx_o    <= shift[1];
                            end
                        end else begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end
                    end
`ifdef WB_UART_TX_PARITY_EN
                    PARITY: begin
                        if (bit_cnt == '0) begin
                            state   <= STOP;
                            tx_o    <= 1'b1;
                            bit_cnt <= div_lat;
                        end else begin
                            bit_cnt <= bit_cnt - 16'd1;
                        end
                    end
`endif
                    STOP: begin
                        if (bit_cnt == '0) state <= IDLE;
                        else               bit_cnt <= bit_cnt - 16'd1;
                    end
                    IDLE:    tx_o  <= 1'b1;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wb_uart_tx.sv
// Scoreboarded bench for wb_uart_tx: bus reads and serial frames are checked by independent monitors.
module tb_wb_uart_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic irq;

    always #5 clk = ~clk;

    if_wb bus();

    wb_uart_tx dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .wb        (bus),
        .tx_o      (tx),
        .irq_o     (irq)
    );

`ifdef WB_UART_TX_PARITY_EN
    localparam logic [15:0] PAR   = 16'h0010;
    localparam int          NBITS = 11;
`else
    localparam logic [15:0] PAR   = 16'h0000;
    localparam int          NBITS = 10;
`endif
    localparam logic [15:0] ST_IDLE = 16'h0004 | PAR;

    typedef struct {
        logic [7:0] data;
        int         cpb;
        bit         gapless;
    } frame_t;

    typedef struct {
        string       name;
        logic [15:0] val;
    } rd_exp_t;

    frame_t  exp_frames[$];
    rd_exp_t exp_rd[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input frame_t f, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return f.data[i-1];
`ifdef WB_UART_TX_PARITY_EN
        if (i == 9) return ^f.data;
`endif
        return 1'b1;
    endfunction

    // Read-data monitor: compares every read ack against the head of the expectation queue.
    always @(posedge clk) begin
        #2;
        if (!rst && bus.ack && bus.cyc && !bus.we) begin
            if (exp_rd.size() == 0) begin
                check("unexpected_read", exp_rd.size(), 1);
            end else begin
                rd_exp_t e;
                e = exp_rd.pop_front();
                check(e.name, bus.dat_s, e.val);
            end
        end
    end

    // Serial monitor: samples tx every clock and checks each expected frame bit-by-bit.
    int     cyc_n    = 0;
    int     last_end = -100;
    int     mon_cnt  = 0;
    int     mon_bit  = 0;
    logic   mon_active = 1'b0;
    logic   mon_ignore = 1'b0;
    logic   mon_dead   = 1'b0;
    logic   bit_ok;
    logic [7:0] obs;
    frame_t cur;

    always @(negedge clk) begin
        cyc_n++;
        if (rst || mon_ignore || mon_dead) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && tx == 1'b0) begin
                if (exp_frames.size() == 0) begin
                    check("unexpected_start", exp_frames.size(), 1);
                    mon_dead = 1'b1;
                end else begin
                    cur        = exp_frames.pop_front();
                    mon_active = 1'b1;
                    mon_bit    = 0;
                    mon_cnt    = 0;
                    bit_ok     = 1'b1;
                    obs        = '0;
                    if (cur.gapless) check("frame_gap", cyc_n - last_end, 1);
                end
            end
            if (mon_active) begin
                if (tx !== frame_bit(cur, mon_bit)) bit_ok = 1'b0;
                if (mon_bit >= 1 && mon_bit <= 8 && mon_cnt == 0) obs[mon_bit-1] = tx;
                mon_cnt++;
                if (mon_cnt == cur.cpb) begin
                    mon_cnt = 0;
                    mon_bit++;
                    if (mon_bit == NBITS) begin
                        check("frame_data", obs, cur.data);
                        check("frame_shape", bit_ok, 1);
                        mon_active = 1'b0;
                        last_end   = cyc_n;
                    end
                end
            end
        end
    end

    // Bus tasks are entered and left just after a falling edge.
    task automatic bus_cycle(input logic [1:0] a, input logic w, input logic [15:0] d);
        int n = 0;
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = w;
        bus.adr   = {14'b0, a};
        bus.dat_m = d;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.ack && n < 8);
        if (!bus.ack) check("ack_timeout", bus.ack, 1);
        @(negedge clk);
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus_cycle(a, 1'b1, d);
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string name);
        rd_exp_t e;
        e.name = name;
        e.val  = exp;
        exp_rd.push_back(e);
        bus_cycle(a, 1'b0, 16'h0);
    endtask

    task automatic send(input logic [7:0] d, input int cpb, input bit gapless);
        frame_t f;
        f.data    = d;
        f.cpb     = cpb;
        f.gapless = gapless;
        exp_frames.push_back(f);
        wr(2'd0, {8'h00, d});
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((exp_frames.size() != 0 || mon_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_frames.size() != 0 || mon_active) begin
            check(name, exp_frames.size() + int'(mon_active), 0);
            exp_frames.delete();
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cyc   = 1'b0;
        bus.stb   = 1'b0;
        bus.we    = 1'b0;
        bus.adr   = '0;
        bus.dat_m = '0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_irq", irq, 1);
        check("rst_ack", bus.ack, 0);
        check("rst_dat_s", bus.dat_s, 0);
        rst = 1'b0;
        @(negedge clk);

        // Reset register values and the reserved slot.
        rd(2'd1, ST_IDLE, "status_reset");
        rd(2'd2, 16'd867, "div_reset");
        rd(2'd3, 16'h0000, "reserved_read");
        wr(2'd3, 16'h1234);
        rd(2'd2, 16'd867, "div_after_reserved_write");
        rd(2'd0, 16'h0000, "data_read");

        // Single frame at 4 clocks per bit.
        wr(2'd2, 16'd3);
        rd(2'd2, 16'd3, "div_write");
        send(8'h55, 4, 1'b0);
        repeat (10) @(negedge clk);
        check("irq_busy", irq, 0);
        rd(2'd1, 16'h0005 | PAR, "status_busy");
        wait_idle(100, "timeout_0x55");
        repeat (3) @(negedge clk);
        check("irq_idle", irq, 1);
        rd(2'd1, ST_IDLE, "status_after_frame");

        // DIV=0: 17 back-to-back writes all accepted because the FSM drains while writing.
        wr(2'd2, 16'd0);
        for (int i = 0; i < 17; i++) send(8'(i), 1, i != 0);
        wait_idle(400, "timeout_burst");
        repeat (3) @(negedge clk);
        rd(2'd1, ST_IDLE, "status_no_overflow");

        // Stall the FSM on a huge divisor, fill the FIFO, then overflow it.
        wr(2'd2, 16'hFFFF);
        mon_ignore = 1'b1;
        wr(2'd0, 16'h00EE);
        for (int i = 0; i < 16; i++) wr(2'd0, 16'(8'h20 + i));
        rd(2'd1, 16'h1003 | PAR, "status_full");
        wr(2'd0, 16'h0099);
        rd(2'd1, 16'h100B | PAR, "status_overflow");
        wr(2'd1, 16'h0008);
        rd(2'd1, 16'h1003 | PAR, "status_overflow_cleared");
        check("tx_stalled_start", tx, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_stall_tx", tx, 1);
        @(negedge clk);
        rst = 1'b0;
        rd(2'd1, ST_IDLE, "status_flushed");
        mon_ignore = 1'b0;

        // Two gapless frames at DIV=1.
        wr(2'd2, 16'd1);
        send(8'hA5, 2, 1'b0);
        send(8'h3C, 2, 1'b1);
        wait_idle(100, "timeout_pair");

        // DIV change mid-frame applies to the next frame only.
        wr(2'd2, 16'd2);
        send(8'h5A, 3, 1'b0);
        repeat (10) @(negedge clk);
        wr(2'd2, 16'd9);
        send(8'hC3, 10, 1'b1);
        wait_idle(250, "timeout_div_change");

        // Parity-sensitive byte: 10 or 11 bit frame depending on the build.
        wr(2'd2, 16'd1);
        send(8'h07, 2, 1'b0);
        wait_idle(100, "timeout_0x07");
        repeat (3) @(negedge clk);

        // Reset in the middle of the data bits.
        wr(2'd2, 16'd2);
        mon_ignore = 1'b1;
        wr(2'd0, 16'h0000);
        wr(2'd0, 16'h0011);
        repeat (8) @(negedge clk);
        check("tx_mid_data", tx, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_ack", bus.ack, 0);
        @(negedge clk);
        rst = 1'b0;
        mon_ignore = 1'b0;
        rd(2'd1, ST_IDLE, "status_after_mid_reset");
        rd(2'd2, 16'd867, "div_after_mid_reset");
        repeat (60) @(negedge clk);
        check("tx_no_resume", tx, 1);
        check("irq_after_mid_reset", irq, 1);

        repeat (4) @(negedge clk);
        check("read_queue_drained", exp_rd.size(), 0);
        check("frame_queue_drained", exp_frames.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_uart_tx.md
Name: wb_uart_tx

Overview:
- Wishbone classic slave (responder) that the J1 data-bus master writes to transmit serial bytes; attaches to one I/O slot of wb_intercon (e.g. wbs2_2).
- Bytes written are queued in a TX FIFO, then serialised 8N1, LSB first, at a programmable baud divisor.
- Status is readable over the same bus.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of 2, minimum 2.
- DEFAULT_DIV, 867, divisor reset value; clocks per bit = DIV+1 (100 MHz / 115200).

Ports:
- sys_clk_i  input  1  system clock; all logic on rising edge.
- sys_rst_i  input  1  synchronous, active-high reset.
- wb  if_wb.slave  -  Wishbone slave.
  - Uses cyc, stb, we, adr (word address, 2 LSBs decoded), dat_m (16-bit write data), dat_s (16-bit read data), ack.
- tx_o  output  1  serial line; idle high.
- irq_o  output  1  level interrupt; high while FIFO empty and shifter idle.

Behaviour:
- Reset values: ack=0, dat_s=0, tx_o=1, irq_o=1, FIFO empty, DIV=DEFAULT_DIV, overflow=0, FSM=IDLE.
- Bus handshake:
  - ack is registered and asserted one cycle after cyc&stb is sampled with ack=0.
  - ack is high for exactly one cycle, then low for at least one cycle; back-to-back accesses therefore take 2 cycles each.
  - No wait states beyond this; err/rty never asserted.
  - Write side effects and read data are both committed in the ack cycle.
- Register map (adr[1:0]):
  - 0 DATA, W: dat_m[7:0] pushed to FIFO. R: 0.
  - 1 STATUS, R: bit0 busy (FSM≠IDLE), bit1 full, bit2 empty, bit3 overflow, bits[15:8] FIFO level. W: writing 1 to bit3 clears overflow.
  - 2 DIV, R/W: 16-bit divisor.
  - 3: reserved; reads 0, writes ignored, still acked.
- FIFO full on a DATA write: write is acked, byte dropped, overflow set (sticky).
- Push and pop in the same cycle:
  - Both take effect and level is unchanged.
  - Allowed when full; the pop frees the slot.
- TX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: if FIFO non-empty, pop the head into the shift register, latch DIV into the bit counter reload, go to START.
  - START: drive tx_o=0 for DIV+1 clocks.
  - DATA: 8 bits LSB first, each DIV+1 clocks; 3-bit index counter.
  - STOP: drive tx_o=1 for DIV+1 clocks. Then, if FIFO non-empty, pop and go directly to START with no idle gap; else go to IDLE.
  - Frame length is exactly 10*(DIV+1) clocks.
- A DIV write mid-frame affects only the next frame (divisor latched at frame start). DIV=0 gives 1 clock per bit.
- tx_o is driven from a flop; there is no combinational path from bus to tx_o.
- Reset mid-frame: tx_o returns to 1 the cycle after reset, FIFO is flushed, no partial frame resumes.
- irq_o = empty & (FSM==IDLE), registered.

Optional Feature:
- Macro WB_UART_TX_PARITY_EN: adds state PARITY between DATA and STOP.
  - Drives the even parity bit (XOR of the 8 data bits) for DIV+1 clocks.
  - Frame becomes 11*(DIV+1) clocks.
  - STATUS bit4 reads 1.
- Without the macro: no PARITY state, 10-bit frame, STATUS bit4 reads 0.

Decomposition:
- Package wb_uart_pkg holds:
  - tx_state_e enum (IDLE, START, DATA, PARITY, STOP).
  - Register address localparams (ADR_DATA=0, ADR_STATUS=1, ADR_DIV=2).
  - STATUS bit-index constants.
- Sub-module sync_fifo: parameterised width/depth, synchronous reset; push/pop/full/empty/level; read data valid in the cycle pop is asserted (first-word fall-through).

Test Plan:
- Reset, then read STATUS -> 0x0004 (empty); tx_o=1; irq_o=1; read DIV -> 867.
- Write DIV=3, then DATA=0x55 -> tx_o shows start 0, then 1,0,1,0,1,0,1,0, then stop 1, each bit 4 clocks; frame 40 clocks; busy=1 during frame; irq_o returns 1 after stop.
- Write DIV=0, then 17 DATA writes (0x00..0x10) back-to-back -> 16 bytes enqueued, with the first popped early so all 17 are accepted. Confirm overflow only when writes exceed free slots: fill 16 while FSM stalled by DIV=0xFFFF -> 17th write sets STATUS bit3; writing STATUS=0x0008 clears it.
- Two queued bytes 0xA5, 0x3C at DIV=1 -> consecutive frames with no idle gap between the stop bit and the next start bit; 20 clocks each.
- Write DIV=9 mid-frame at DIV=2 -> current frame stays at 3 clocks/bit, next frame uses 10 clocks/bit.
- Assert sys_rst_i mid-DATA -> next cycle tx_o=1, STATUS=0x0004, DIV=867, ack=0.
- With WB_UART_TX_PARITY_EN: send 0x07 -> parity bit 1, frame 11*(DIV+1) clocks.
